// File: rtl/spart_driver_pkg.sv
// Shared definitions for the SPART echo driver: FSM states, SPART
// register addresses and the baud-rate divisor table.
package spart_driver_pkg;

    typedef enum logic [2:0] {
        PROG_LO,
        PROG_HI,
        IDLE,
        RD_RX,
        WR_TX
    } state_e;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Divisors for a 50 MHz clock, clk/(16*baud)-1 rounded, indexed by br_cfg.
    localparam logic [15:0] DIVISOR_TABLE [4] = '{16'd650, 16'd325, 16'd162, 16'd80};

    function automatic logic [15:0] divisorFor(input logic [1:0] cfg);
        return DIVISOR_TABLE[cfg];
    endfunction

endpackage

// File: rtl/spart_fifo.sv
// Synchronous byte FIFO that buffers received bytes until they are echoed.
module spart_fifo
    import spart_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [7:0]             wdata_i,
    output logic [7:0]             rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic          doPush;
    logic          doPop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// SPART echo driver: programs the baud divisor, then echoes every received
// byte back out through a small FIFO, one bus access per cycle.
module spart_driver
    import spart_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             br_cfg,
    input  logic                   rda,
    input  logic                   tbr,
    output logic                   iocs,
    output logic                   iorw,
    output logic [1:0]             ioaddr,
    inout  wire  [7:0]             databus,
    output logic                   init_done,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    state_e      state_q;
    state_e      state_d;
    logic [1:0]  cfg_q;
    logic [1:0]  cfg_d;
    logic        initDone_q;
    logic        initDone_d;
    logic [7:0]  busOut;
    logic [15:0] divisor;
    logic        fifoPush;
    logic        fifoPop;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [7:0]  fifoHead;

    assign divisor   = divisorFor(br_cfg);
    assign init_done = initDone_q;

    spart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .wdata_i (databus),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifo_cnt)
    );

    assign databus = (iocs && !iorw) ? busOut : 8'hzz;

    // State, latched baud select and init flag; reset restarts divisor programming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PROG_LO;
            cfg_q      <= 2'b00;
            initDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            initDone_q <= initDone_d;
        end
    end

    // Next state and bus outputs; every access returns to IDLE so rda/tbr can settle,
    // and the bus is forced quiet while reset is held so an aborted access ends at once.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        initDone_d = initDone_q;
        iocs       = 1'b0;
        iorw       = 1'b1;
        ioaddr     = ADDR_BUF;
        busOut     = 8'h00;
        fifoPush   = 1'b0;
        fifoPop    = 1'b0;
        case (state_q)
            PROG_LO: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = ADDR_DBL;
                busOut  = divisor[7:0];
                state_d = PROG_HI;
            end
            PROG_HI: begin
                iocs       = 1'b1;
                iorw       = 1'b0;
                ioaddr     = ADDR_DBH;
                busOut     = divisor[15:8];
                cfg_d      = br_cfg;
                initDone_d = 1'b1;
                state_d    = IDLE;
            end
            IDLE: begin
                if (br_cfg != cfg_q) begin
                    initDone_d = 1'b0;
                    state_d    = PROG_LO;
                end else if (rda && !fifoFull) begin
                    state_d = RD_RX;
                end else if (tbr && !fifoEmpty) begin
                    state_d = WR_TX;
                end
            end
            RD_RX: begin
                iocs     = 1'b1;
                iorw     = 1'b1;
                ioaddr   = ADDR_BUF;
                fifoPush = 1'b1;
                state_d  = IDLE;
            end
            WR_TX: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = ADDR_BUF;
                busOut  = fifoHead;
                fifoPop = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = PROG_LO;
            end
        endcase
        if (!rst_n) begin
            iocs     = 1'b0;
            iorw     = 1'b1;
            ioaddr   = ADDR_BUF;
            fifoPush = 1'b0;
            fifoPop  = 1'b0;
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a SPART model feeds bytes, and a transaction-level
// model (byte queues plus the arbitration rules) predicts every bus access.
module tb_spart_driver;
    import spart_driver_pkg::*;

    localparam int DEPTH = 4;
    localparam int K_NONE = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_PLO  = 3;
    localparam int K_PHI  = 4;
    localparam int K_BAD  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       init_done;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic [7:0] tbDrive;

    int errors = 0;
    int checks = 0;

    logic [7:0] rxQueue[$];
    logic [7:0] modelFifo[$];
    logic [7:0] txLog[$];
    logic [7:0] readLog[$];
    logic       modelInit = 1'b0;
    logic [1:0] modelCfg = 2'b00;
    logic       lastIdle = 1'b0;
    int         prevKind = K_NONE;
    logic       expValid = 1'b0;
    int         expKind = K_NONE;

    spart_driver #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .br_cfg    (br_cfg),
        .rda       (rda),
        .tbr       (tbr),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .init_done (init_done),
        .fifo_cnt  (fifo_cnt)
    );

    // The SPART model drives the bus only while the driver reads from it.
    assign databus = (iocs && iorw) ? tbDrive : 8'hzz;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the bench itself gets stuck somewhere.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Divisor from the baud formula: round(50e6 / (16*baud)) - 1.
    function automatic logic [15:0] refDivisor(input logic [1:0] cfg);
        int baud;
        baud = 4800 << cfg;
        return 16'((50_000_000 + 8 * baud) / (16 * baud) - 1);
    endfunction

    function automatic int decodeKind();
        if (!iocs) return K_NONE;
        if (iorw) return (ioaddr == ADDR_BUF) ? K_RD : K_BAD;
        case (ioaddr)
            ADDR_BUF:  return K_WR;
            ADDR_DBL:  return K_PLO;
            ADDR_DBH:  return K_PHI;
            ADDR_STAT: return K_BAD;
            default:   return K_BAD;
        endcase
    endfunction

    // Predict the next access from what the driver sees at this edge, but only
    // when the cycle just ending was idle (arbitration happens only in IDLE).
    always @(posedge clk) begin
        if (rst_n && lastIdle) begin
            expValid = 1'b1;
            if (!modelInit || br_cfg != modelCfg) expKind = K_PLO;
            else if (rda && modelFifo.size() < DEPTH) expKind = K_RD;
            else if (tbr && modelFifo.size() > 0) expKind = K_WR;
            else expKind = K_NONE;
        end else begin
            expValid = 1'b0;
        end
    end

    // Observe each cycle mid-way: check occupancy, access order, bus contents,
    // then advance the reference queues for the access that just happened.
    always @(negedge clk) begin
        int kind;
        logic [15:0] div;
        if (!rst_n) begin
            lastIdle = 1'b0;
            prevKind = K_NONE;
        end else begin
            kind = decodeKind();
            div = refDivisor(br_cfg);
            checkOutput("fifo_cnt", 32'(fifo_cnt), 32'(modelFifo.size()));
            if (expValid) checkOutput("next_access", 32'(kind), 32'(expKind));
            if (prevKind == K_PLO) checkOutput("plo_then_phi", 32'(kind), 32'(K_PHI));
            else if (prevKind != K_NONE) checkOutput("idle_gap", 32'(kind), 32'(K_NONE));
            if (kind == K_PLO) modelInit = 1'b0;
            checkOutput("init_done", 32'(init_done), 32'(modelInit));
            case (kind)
                K_NONE: begin
                    checkOutput("idle_ctl", 32'({iorw, ioaddr}), 32'(3'b100));
                    checkOutput("idle_hiz", 32'(databus === 8'hzz), 32'd1);
                end
                K_PLO: checkOutput("div_lo", 32'(databus), 32'(div[7:0]));
                K_PHI: begin
                    checkOutput("div_hi", 32'(databus), 32'(div[15:8]));
                    modelCfg  = br_cfg;
                    modelInit = 1'b1;
                end
                K_RD: begin
                    tbDrive = (rxQueue.size() > 0) ? rxQueue[0] : 8'h00;
                    if (rxQueue.size() > 0) void'(rxQueue.pop_front());
                    rda = (rxQueue.size() > 0);
                    if (modelFifo.size() < DEPTH) modelFifo.push_back(tbDrive);
                    readLog.push_back(tbDrive);
                end
                K_WR: begin
                    checkOutput("wr_occupancy", 32'(modelFifo.size() > 0), 32'd1);
                    if (modelFifo.size() > 0) begin
                        checkOutput("wr_data", 32'(databus), 32'(modelFifo[0]));
                        void'(modelFifo.pop_front());
                    end
                    txLog.push_back(databus);
                end
                default: checkOutput("bad_access", 32'(kind), 32'(K_NONE));
            endcase
            lastIdle = (kind == K_NONE);
            prevKind = kind;
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        #1;
        rxQueue.push_back(b);
        rda = 1'b1;
    endtask

    task automatic waitDrain(input string tag, input int maxCycles);
        int n = 0;
        while ((rxQueue.size() > 0 || modelFifo.size() > 0) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drained"}, 32'(rxQueue.size() + modelFifo.size()), 32'd0);
    endtask

    task automatic waitCount(input string tag, input int target, input int maxCycles);
        int n = 0;
        while (int'(fifo_cnt) != target && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_count"}, 32'(fifo_cnt), 32'(target));
    endtask

    // Returns {iorw, ioaddr, databus} of the next bus access seen mid-cycle.
    task automatic waitAccess(input string tag, output logic [10:0] acc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!iocs && n < 40);
        checkOutput({tag, "_seen"}, 32'(iocs), 32'd1);
        acc = {iorw, ioaddr, databus};
    endtask

    task automatic checkTx(input string tag, input int base, input logic [7:0] exp[]);
        checkOutput({tag, "_len"}, 32'(txLog.size()), 32'(base + exp.size()));
        foreach (exp[i]) begin
            if (base + i < txLog.size()) checkOutput({tag, "_byte"}, 32'(txLog[base + i]), 32'(exp[i]));
        end
    endtask

    // Directed scenarios followed by a randomized soak, all in one sequence.
    initial begin
        logic [10:0] acc;
        int base;
        rst_n = 1'b0; br_cfg = 2'b01; tbr = 1'b0; rda = 1'b0; tbDrive = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_iocs", 32'(iocs), 32'd0);
        checkOutput("rst_ctl", 32'({iorw, ioaddr}), 32'(3'b100));
        checkOutput("rst_hiz", 32'(databus === 8'hzz), 32'd1);
        checkOutput("rst_init", 32'(init_done), 32'd0);
        checkOutput("rst_cnt", 32'(fifo_cnt), 32'd0);

        // Baud programming right after reset release, br_cfg = 9600.
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        checkOutput("prog1_addr", 32'({iocs, iorw, ioaddr}), 32'(4'b1010));
        checkOutput("prog1_data", 32'(databus), 32'h45);
        @(negedge clk);
        checkOutput("prog2_addr", 32'({iocs, iorw, ioaddr}), 32'(4'b1011));
        checkOutput("prog2_data", 32'(databus), 32'h01);
        @(negedge clk);
        checkOutput("prog_done", 32'(init_done), 32'd1);

        // Single echo.
        #1; tbr = 1'b1;
        base = txLog.size();
        applyStimulus(8'h5A);
        waitDrain("echo1", 40);
        checkTx("echo1", base, '{8'h5A});

        // Fill to full with TX blocked; the fifth byte stays pending.
        @(negedge clk); #1; tbr = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
        repeat (20) @(negedge clk);
        checkOutput("full_cnt", 32'(fifo_cnt), 32'd4);
        checkOutput("full_pending", 32'(rxQueue.size()), 32'd1);
        base = txLog.size();
        #1; tbr = 1'b1;
        waitDrain("full", 80);
        checkTx("full", base, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});

        // RX wins over TX when both are eligible.
        @(negedge clk); #1; tbr = 1'b0;
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        waitCount("prio", 2, 40);
        #1; rxQueue.push_back(8'hCC); rda = 1'b1; tbr = 1'b1;
        waitAccess("prio_first", acc);
        checkOutput("prio_first_rd", 32'(acc[10:8]), 32'(3'b100));
        waitAccess("prio_second", acc);
        checkOutput("prio_second_wr", 32'(acc), 32'({3'b000, 8'hAA}));
        waitDrain("prio", 60);

        // Reprogram to 38400 with two bytes queued; the queue survives.
        @(negedge clk); #1; tbr = 1'b0;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        waitCount("reprog", 2, 40);
        #1; br_cfg = 2'b11;
        waitAccess("reprog_lo", acc);
        checkOutput("reprog_lo_acc", 32'(acc), 32'({3'b010, 8'h50}));
        checkOutput("reprog_lo_init", 32'(init_done), 32'd0);
        checkOutput("reprog_lo_cnt", 32'(fifo_cnt), 32'd2);
        @(negedge clk);
        checkOutput("reprog_hi_acc", 32'({iorw, ioaddr, databus}), 32'({3'b011, 8'h00}));
        checkOutput("reprog_hi_cnt", 32'(fifo_cnt), 32'd2);
        @(negedge clk);
        checkOutput("reprog_done", 32'(init_done), 32'd1);
        base = txLog.size();
        #1; tbr = 1'b1;
        waitDrain("reprog", 40);
        checkTx("reprog", base, '{8'h11, 8'h22});

        // Randomized soak: random arrivals, TX readiness and occasional baud changes.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (rxQueue.size() < 6 && $urandom_range(0, 2) == 0) begin
                rxQueue.push_back(8'($urandom));
                rda = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) tbr = !tbr;
            if (i % 100 == 50 && init_done && !iocs) br_cfg = 2'($urandom);
        end
        @(negedge clk); #1; tbr = 1'b1;
        waitDrain("soak", 200);
        checkOutput("soak_bytes", 32'(txLog.size()), 32'(readLog.size()));

        // Reset in the middle of a transmit access.
        @(negedge clk); #1; tbr = 1'b0;
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        waitCount("rstwr", 2, 40);
        #1; tbr = 1'b1;
        waitAccess("rstwr", acc);
        checkOutput("rstwr_is_wr", 32'(acc[10:8]), 32'(3'b000));
        #1; rst_n = 1'b0;
        #1;
        checkOutput("rstwr_iocs", 32'(iocs), 32'd0);
        checkOutput("rstwr_hiz", 32'(databus === 8'hzz), 32'd1);
        checkOutput("rstwr_cnt", 32'(fifo_cnt), 32'd0);
        modelFifo.delete(); rxQueue.delete(); rda = 1'b0; tbr = 1'b0; modelInit = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstwr_prog", 32'({iocs, iorw, ioaddr}), 32'(4'b1010));
        repeat (4) @(negedge clk);
        checkOutput("rstwr_init", 32'(init_done), 32'd1);
        checkOutput("rstwr_cnt_after", 32'(fifo_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
